// File: rtl/digit_tick_sequencer_if.sv
// Command/config inputs and display/bus outputs of the digit tick sequencer.
// The master drives the commands and cfg_div; the slave (the sequencer) returns the display and bus outputs.
interface digit_tick_sequencer_if;
    logic       cmd_start;
    logic       cmd_stop;
    logic       cmd_clear;
    logic [7:0] cfg_div;
    logic [3:0] digit;
    logic       tick;
    logic       wrap;
    logic       running;
    logic [7:0] count_lo;

    modport master (
        output cmd_start, cmd_stop, cmd_clear, cfg_div,
        input  digit, tick, wrap, running, count_lo
    );
    modport slave (
        input  cmd_start, cmd_stop, cmd_clear, cfg_div,
        output digit, tick, wrap, running, count_lo
    );
endinterface

// File: rtl/digit_tick_sequencer.sv
// Run/pause/clear controller for the period counter and the 0..DIGIT_MAX digit.
// It emits one-cycle tick and wrap strobes. Every output comes from a register.
module digit_tick_sequencer #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter logic [3:0]  DIGIT_MAX = 4'd9
) (
    input  logic                    clk,
    input  logic                    reset,
    digit_tick_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_counter;
    logic [23:0] r_cmp;
    logic [3:0]  r_digit;
    logic        r_tick;
    logic        r_wrap;
    logic        r_running;
    logic [7:0]  r_count_lo;

    logic        w_launch;
    logic        w_advance;
    logic        w_period_end;
    logic [23:0] w_cmp_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // A stop in the same cycle always masks a start.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.cmd_clear) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.cmd_start && !bus.cmd_stop) w_state_nxt = S_RUN;
                S_RUN:   if (bus.cmd_stop)                   w_state_nxt = S_PAUSE;
                S_PAUSE: if (bus.cmd_start && !bus.cmd_stop) w_state_nxt = S_RUN;
                default:                                     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A counter above the compare value is treated like a match, so the period still ends.
    always_comb begin
        w_launch     = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
        w_advance    = (r_state == S_RUN) && !bus.cmd_clear && !bus.cmd_stop;
        w_period_end = w_advance && (r_counter >= r_cmp);
        w_cmp_sel    = (bus.cfg_div == 8'd0) ? MAX_COUNT : {6'b0, bus.cfg_div, 10'b0};
    end

    // The compare value is loaded only on launch and at a period boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_counter  <= 24'd0;
            r_cmp      <= MAX_COUNT;
            r_digit    <= 4'd0;
            r_tick     <= 1'b0;
            r_wrap     <= 1'b0;
            r_running  <= 1'b0;
            r_count_lo <= 8'd0;
        end else begin
            r_tick     <= w_period_end;
            r_wrap     <= w_period_end && (r_digit >= DIGIT_MAX);
            r_running  <= (w_state_nxt == S_RUN);
            r_count_lo <= r_counter[7:0];
            if (bus.cmd_clear) begin
                r_counter <= 24'd0;
                r_digit   <= 4'd0;
            end else if (w_launch) begin
                r_counter <= 24'd0;
                r_cmp     <= w_cmp_sel;
            end else if (w_period_end) begin
                r_counter <= 24'd0;
                r_cmp     <= w_cmp_sel;
                r_digit   <= (r_digit >= DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
            end else if (w_advance) begin
                r_counter <= r_counter + 24'd1;
            end
        end
    end

    assign bus.digit    = r_digit;
    assign bus.tick     = r_tick;
    assign bus.wrap     = r_wrap;
    assign bus.running  = r_running;
    assign bus.count_lo = r_count_lo;
endmodule

// File: tb/tb_digit_tick_sequencer.sv
// Scoreboard bench for digit_tick_sequencer: directed scenarios plus random commands.
// The reference model predicts the outputs after every clock edge, and a monitor checks them.
module tb_digit_tick_sequencer;
    localparam int TB_MAX = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;

    digit_tick_sequencer_if bus ();

    digit_tick_sequencer #(.MAX_COUNT(24'd5), .DIGIT_MAX(4'd9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int digit;
        bit tick;
        bit wrap;
        bit running;
        int count_lo;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model: 0 = idle, 1 = run, 2 = pause.
    int m_mode = 0;
    int m_cnt = 0;
    int m_dig = 0;
    int m_cmp = TB_MAX;
    int div = 0;

    function automatic int period_cmp(input int d);
        return (d == 0) ? TB_MAX : d * 1024;
    endfunction

    task automatic model_step(input bit s, input bit t, input bit c, output exp_t e);
        int prev;
        prev = m_cnt;
        e.tick = 0;
        e.wrap = 0;
        if (c) begin
            m_mode = 0; m_cnt = 0; m_dig = 0;
        end else if (m_mode == 0) begin
            if (s && !t) begin m_mode = 1; m_cnt = 0; m_cmp = period_cmp(div); end
        end else if (m_mode == 2) begin
            if (s && !t) m_mode = 1;
        end else if (t) begin
            m_mode = 2;
        end else if (m_cnt >= m_cmp) begin
            m_cnt = 0;
            m_cmp = period_cmp(div);
            e.tick = 1;
            e.wrap = (m_dig == 9);
            m_dig = (m_dig + 1) % 10;
        end else begin
            m_cnt++;
        end
        e.digit    = m_dig;
        e.running  = (m_mode == 1);
        e.count_lo = prev % 256;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the following negedge, with outputs showing the effect of this cycle's commands.
    task automatic cyc(input bit s, input bit t, input bit c);
        exp_t e;
        bus.cmd_start = s;
        bus.cmd_stop  = t;
        bus.cmd_clear = c;
        bus.cfg_div   = 8'(div);
        model_step(s, t, c, e);
        @(posedge clk);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wait_tick(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            cyc(0, 0, 0);
            n++;
            if (bus.tick) return;
        end
        total++;
        bad++;
        $display("FAIL wait_tick: no tick within %0d cycles", maxc);
    endtask

    task automatic do_reset();
        bus.cmd_start = 0; bus.cmd_stop = 0; bus.cmd_clear = 0;
        reset = 1'b1;
        #1;
        chk("async_rst_digit", int'(bus.digit), 0);
        chk("async_rst_running", int'(bus.running), 0);
        chk("async_rst_tick", int'(bus.tick), 0);
        chk("async_rst_count_lo", int'(bus.count_lo), 0);
        q.delete();
        m_mode = 0; m_cnt = 0; m_dig = 0; m_cmp = TB_MAX;
        @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: compares one expected record per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (int'(bus.digit) != e.digit || bus.tick != e.tick || bus.wrap != e.wrap ||
                    bus.running != e.running || int'(bus.count_lo) != e.count_lo) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got d=%0d t=%0b w=%0b r=%0b lo=%0d expected d=%0d t=%0b w=%0b r=%0b lo=%0d",
                             $time, bus.digit, bus.tick, bus.wrap, bus.running, bus.count_lo,
                             e.digit, e.tick, e.wrap, e.running, e.count_lo);
                end
            end
        end
    end

    initial begin
        int n;
        int ticks;
        bit s, t, c;
        bus.cmd_start = 0; bus.cmd_stop = 0; bus.cmd_clear = 0; bus.cfg_div = 8'd0;
        #3;
        chk("reset_digit", int'(bus.digit), 0);
        chk("reset_tick", int'(bus.tick), 0);
        chk("reset_wrap", int'(bus.wrap), 0);
        chk("reset_running", int'(bus.running), 0);
        chk("reset_count_lo", int'(bus.count_lo), 0);
        #4 reset = 1'b0;
        @(negedge clk);

        // Default period of 6 cycles, digit sequence, and wrap on the tenth tick
        div = 0;
        cyc(1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            wait_tick(20, n);
            chk("t1_period", n, 6);
            chk("t1_digit", int'(bus.digit), i % 10);
            chk("t1_wrap", int'(bus.wrap), (i == 10) ? 1 : 0);
        end

        // cfg_div=1 gives 1025-cycle periods, and a change takes effect only at the next period boundary
        cyc(0, 0, 1);
        div = 1;
        cyc(1, 0, 0);
        wait_tick(1100, n);
        chk("t2_first_period", n, 1025);
        repeat (400) cyc(0, 0, 0);
        div = 2;
        wait_tick(1000, n);
        chk("t2_old_period_rest", n, 625);
        wait_tick(2100, n);
        chk("t2_new_period", n, 2049);
        div = 0;

        // Pause with the counter at 3, then resume
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        repeat (3) cyc(0, 0, 0);
        cyc(0, 1, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0);
            if (bus.tick) ticks++;
        end
        chk("t3_pause_ticks", ticks, 0);
        chk("t3_pause_count_lo", int'(bus.count_lo), 3);
        chk("t3_pause_running", int'(bus.running), 0);
        cyc(1, 0, 0);
        wait_tick(10, n);
        chk("t3_resume_to_tick", n, 3);

        // Stop exactly when counter == cmp_q
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        repeat (5) cyc(0, 0, 0);
        cyc(0, 1, 0);
        chk("t4_stop_tick", int'(bus.tick), 0);
        chk("t4_stop_count_lo", int'(bus.count_lo), 5);
        cyc(1, 0, 0);
        wait_tick(10, n);
        chk("t4_resume_tick", n, 1);

        // All three commands at once in RUN, then start+stop from IDLE
        cyc(0, 0, 1);
        cyc(1, 0, 0);
        for (int i = 0; i < 7; i++) wait_tick(20, n);
        repeat (2) cyc(0, 0, 0);
        chk("t5_digit_before", int'(bus.digit), 7);
        cyc(1, 1, 1);
        chk("t5_clear_digit", int'(bus.digit), 0);
        chk("t5_clear_tick", int'(bus.tick), 0);
        chk("t5_clear_wrap", int'(bus.wrap), 0);
        chk("t5_clear_running", int'(bus.running), 0);
        cyc(1, 1, 0);
        chk("t5_idle_start_stop", int'(bus.running), 0);
        chk("t5_idle_count_lo", int'(bus.count_lo), 0);

        // Asynchronous reset mid-period at digit 4
        cyc(1, 0, 0);
        for (int i = 0; i < 4; i++) wait_tick(20, n);
        repeat (2) cyc(0, 0, 0);
        chk("t6_digit_before", int'(bus.digit), 4);
        chk("t6_running_before", int'(bus.running), 1);
        do_reset();
        repeat (10) cyc(0, 0, 0);
        chk("t6_after_rst_running", int'(bus.running), 0);
        chk("t6_after_rst_digit", int'(bus.digit), 0);

        // Random command mix against the model
        for (int i = 0; i < 6000; i++) begin
            c = ($urandom_range(0, 99) < 2);
            t = ($urandom_range(0, 99) < 4);
            s = ($urandom_range(0, 99) < 10);
            if ($urandom_range(0, 799) == 0) div = ($urandom_range(0, 3) == 0) ? 1 : 0;
            if ($urandom_range(0, 1999) == 0) do_reset();
            else cyc(s, t, c);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/digit_tick_sequencer.md
Name: digit_tick_sequencer

Overview:
- Run/pause/clear controller for the seconds-counter and decimal-digit datapath that drives the seven-segment output.
- Owns the 24-bit period counter and the 0–9 digit register.
- Selects the period compare value from the switch inputs and emits one-cycle tick and wrap strobes for downstream display and bus logic.
- Sits between the top-level pin wrapper (switches, push-button commands) and the seg7 decoder.

Parameters:
- MAX_COUNT, 24'd10_000_000, compare value used when cfg_div == 0 (1 s at 10 MHz).
- DIGIT_MAX, 4'd9, last digit value before wrap to 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  start/resume request, level-sampled each cycle.
- cmd_stop  in  1  pause request.
- cmd_clear  in  1  return to zero and idle.
- cfg_div  in  8  period select; 0 = MAX_COUNT, else compare = {6'b0, cfg_div, 10'b0}.
- digit  out  4  current digit, 0..DIGIT_MAX, feeds seg7.
- tick  out  1  one-cycle pulse per completed period.
- wrap  out  1  one-cycle pulse when digit rolls DIGIT_MAX -> 0.
- running  out  1  high while in RUN.
- count_lo  out  8  period counter bits [7:0], for the bidirectional bus.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values:
  - state = IDLE
  - counter = 0, digit = 0
  - cmp_q = MAX_COUNT
  - tick = 0, wrap = 0, running = 0, count_lo = 0
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE: counter and digit held at 0.
  - RUN: counting.
  - PAUSE: counter and digit frozen.
- Command priority, same cycle: clear > stop > start.
- Transitions:
  - cmd_clear in any state -> IDLE; counter = 0, digit = 0; tick and wrap suppressed that cycle.
  - IDLE + cmd_start -> RUN; cmd_q latches the compare decoded from cfg_div; counter starts at 0.
  - RUN + cmd_stop -> PAUSE; counter holds its current value and does not advance that cycle; any tick due that cycle is suppressed.
  - PAUSE + cmd_start -> RUN; resumes from the held counter; cmp_q is not re-latched.
  - Ignored: cmd_start in RUN; cmd_stop in IDLE or PAUSE.
- Counting in RUN, each cycle with no stop or clear:
  - If counter == cmp_q: counter <= 0; digit increments; tick <= 1 on the next cycle, coincident with the new digit value.
  - If digit == DIGIT_MAX at that point: digit <= 0 and wrap <= 1, same cycle as tick.
  - Otherwise counter <= counter + 1.
  - Period is therefore cmp_q + 1 cycles.
- Compare update:
  - cmp_q re-latches from cfg_div on every wrap of counter to 0, so a cfg_div change takes effect at the next period boundary, never mid-period.
  - cfg_div == 0 selects MAX_COUNT.
  - Minimum non-zero compare is 1024; maximum is 261120.
- Counter safety: if counter > cmp_q (not reachable in normal use), treat it as equal: wrap to 0 and tick.
- Strobes: tick and wrap are high for exactly one cycle and never in IDLE or PAUSE.
- running = (state == RUN), registered.
- count_lo mirrors counter[7:0] one cycle late.
- Reset mid-count: all state returns to reset values immediately and asynchronously; first count requires a fresh cmd_start.

Test Plan:
- MAX_COUNT=5, cfg_div=0, pulse cmd_start -> tick every 6 cycles; digit goes 1,2,…,9,0; wrap on the 10th tick only, same cycle as tick.
- cfg_div=1, start -> first tick exactly 1025 cycles after start is sampled. Change cfg_div to 2 mid-period -> that period stays 1025; the next period is 2049 cycles.
- MAX_COUNT=5, RUN with counter=3, assert cmd_stop -> running=0 and count_lo holds 3 for 20 cycles, no tick. cmd_start -> tick after 3 more cycles (counter 4,5, then wrap).
- cmd_stop asserted in the cycle counter==cmp_q -> no tick, counter stays at cmp_q. After resume, tick on the first RUN cycle's next edge.
- cmd_start+cmd_stop+cmd_clear together while in RUN with digit=7 -> IDLE, digit=0, counter=0, no tick or wrap. cmd_start+cmd_stop from IDLE -> stays IDLE.
- Assert reset asynchronously mid-period at digit=4 -> all outputs 0 before the next clk edge. After release, no counting until cmd_start.
